// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants.
// Imported by the schedule controller and its testbench.
package aes_pkg;

  localparam int AES_KEY_W     = 128;
  localparam int AES128_ROUNDS = 10;
  localparam int RK_IDX_W      = 4;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_DONE
  } ks_state_t;

endpackage

// File: rtl/gen_key.sv
// Single AES-128 key-expansion round.
// Purely combinational: next round key from current key and round index.
module gen_key (
  input  logic [3:0]   round,
  input  logic [127:0] key_in,
  output logic [127:0] key_out
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0 sits in the top byte of the table.
  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [7:0] idx;
    idx = 8'hff ^ b;
    return SBOX[{idx, 3'b000} +: 8];
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = key_in;

  assign t = {sb(w3[23:16]) ^ rcon,
              sb(w3[15:8]),
              sb(w3[7:0]),
              sb(w3[31:24])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion into an 11-entry round-key file.
// One gen_key round per clock; registered indexed read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  ks_state_t    state_q, state_d;
  logic [127:0] cur_q, cur_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         rk_valid_q, rk_valid_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [127:0] slot_q [0:NUM_ROUNDS];
  logic [127:0] slot_d [0:NUM_ROUNDS];
  logic [127:0] gk_out;

  gen_key u_gen_key (
    .round   (rnd_q),
    .key_in  (cur_q),
    .key_out (gk_out)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rnd_d      = rnd_q;
    rk_valid_d = rk_valid_q;
    slot_d     = slot_q;
    rk_out_d   = '0;
    if (rk_idx <= LAST_IDX) begin
      rk_out_d = slot_q[rk_idx];
    end
    unique case (state_q)
      KS_IDLE, KS_DONE: begin
        if (key_valid) begin
          slot_d[0]  = key_in;
          cur_d      = key_in;
          rnd_d      = 4'd0;
          rk_valid_d = 1'b0;
          state_d    = KS_EXPAND;
        end
      end
      KS_EXPAND: begin
        cur_d                  = gk_out;
        slot_d[rnd_q + 4'd1]   = gk_out;
        // rnd holds at the last round so it never exceeds 9.
        if (rnd_q == LAST_RND) begin
          state_d    = KS_DONE;
          rk_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= KS_IDLE;
      cur_q      <= '0;
      rnd_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rnd_q      <= rnd_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
      slot_q     <= slot_d;
    end
  end

  assign key_ready = (state_q != KS_EXPAND);
  assign busy      = (state_q == KS_EXPAND);
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;

endmodule
